dmem_block_mover: RTL and testbench

Block-transfer initiator that drives the data-memory port (address, write data, read data, read/write strobes) to copy a run of words from one region to another, or to fill a region with a constant. It sits beside the CPU datapath on the data-memory bus and is started by a single-cycle command. The memory it drives has combinational read and posedge synchronous write; this block is the master side of that interface.

---
 rtl/dmem_block_mover_if.sv | 31 +++
 rtl/dmem_block_mover.sv | 146 ++++++++++++++
 tb/tb_dmem_block_mover.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_block_mover_if.sv
// Data-memory port between the block mover (master) and a memory with
// combinational read and posedge synchronous write (slave).
interface dmem_block_mover_if #(
  parameter int S  = 32,
  parameter int AW = 8
);
  // No valid/ready here: a strobe is a complete access for the cycle it is
  // high. mread means dout is consumed this cycle; mwrite commits din to a
  // at the next posedge.
  logic [AW-1:0] a;
  logic [S-1:0]  din;
  logic [S-1:0]  dout;
  logic          mread;
  logic          mwrite;

  modport master (
    output a,
    output din,
    output mread,
    output mwrite,
    input  dout
  );

  modport slave (
    input  a,
    input  din,
    input  mread,
    input  mwrite,
    output dout
  );
endinterface

// File: rtl/dmem_block_mover.sv
// Block-transfer initiator: copies a run of words between memory regions, or
// fills a region with a constant, by driving the data-memory port.
module dmem_block_mover #(
  parameter int S  = 32,
  parameter int L  = 256,
  parameter int AW = $clog2(L)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [AW-1:0]        src,
  input  logic [AW-1:0]        dst,
  input  logic [AW:0]          len,
  input  logic [S-1:0]         fill_val,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg_o,
  dmem_block_mover_if.master   mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [S-1:0]    buf_q, buf_d;
  logic            mode_q, mode_d;
  logic [S-1:0]    fill_q, fill_d;

  // Raw per-state bus drive before hold/reset gating.
  logic [AW-1:0]   a_raw;
  logic [S-1:0]    din_raw;
  logic            rd_raw;
  logic            wr_raw;
  logic            bus_blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    a_raw   = '0;
    din_raw = '0;
    rd_raw  = 1'b0;
    wr_raw  = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src;
          dst_d  = dst;
          cnt_d  = len;
          mode_d = mode;
          fill_d = fill_val;
          if (len == '0)   state_d = DONE;
          else if (mode)   state_d = WRITE;
          else             state_d = READ;
        end
      end

      READ: begin
        a_raw  = src_q;
        rd_raw = 1'b1;
        if (!hold) begin
          buf_d   = mem.dout;
          state_d = WRITE;
        end
      end

      WRITE: begin
        a_raw   = dst_q;
        din_raw = mode_q ? fill_q : buf_q;
        wr_raw  = 1'b1;
        if (!hold) begin
          // Pointers are AW bits wide, so they wrap modulo L for free.
          src_d = src_q + AW'(1);
          dst_d = dst_q + AW'(1);
          cnt_d = cnt_q - (AW+1)'(1);
          if (cnt_q == (AW+1)'(1)) state_d = DONE;
          else if (mode_q)         state_d = WRITE;
          else                     state_d = READ;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // The CPU owns the bus during hold, and nothing may reach memory while in
  // reset, so the whole port is forced quiet combinationally in both cases.
  assign bus_blocked = hold | rst;

  always_comb begin
    mem.a      = '0;
    mem.din    = '0;
    mem.mread  = 1'b0;
    mem.mwrite = 1'b0;
    if (!bus_blocked) begin
      mem.a      = a_raw;
      mem.din    = din_raw;
      mem.mread  = rd_raw;
      mem.mwrite = wr_raw;
    end
  end

  assign busy        = (state_q == READ) || (state_q == WRITE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed bench for dmem_block_mover: an access-list model predicts the bus
// trace cycle by cycle and the final memory image.
module tb_dmem_block_mover;
  localparam int S  = 32;
  localparam int L  = 256;
  localparam int AW = 8;
  localparam int EW = 4 + AW + S;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [S-1:0]  fill_val;
  logic          hold;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  dmem_block_mover_if #(.S(S), .AW(AW)) bus ();

  dmem_block_mover #(.S(S), .L(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .fill_val    (fill_val),
    .hold        (hold),
    .busy        (busy),
    .done        (done),
    .state_dbg_o (state_dbg),
    .mem         (bus.master)
  );

  // Memory under the DUT: combinational read, posedge write.
  logic [S-1:0] mem [L];
  logic         mem_init;
  assign bus.dout = mem[bus.a];

  function automatic logic [S-1:0] init_val(input int i);
    if (i >= 16 && i < 20) return 32'hAAAA_00A0 + 32'(i - 16);
    return 32'hC0DE_0000 | 32'(i * 3);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < L; i++) mem[i] <= init_val(i);
    end else if (bus.mwrite) begin
      mem[bus.a] <= bus.din;
    end
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [S-1:0]  exp_mem [L];
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic b, input logic d, input logic r,
                                         input logic w, input logic [AW-1:0] a,
                                         input logic [S-1:0] dat);
    return {b, d, r, w, a, dat};
  endfunction

  // Model: expand the command into its ordered list of accesses, then lay
  // them onto cycles, inserting a bus-quiet cycle for every hold.
  task automatic build_model(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input int n, input logic [S-1:0] f,
                             input logic [63:0] hmask, input int rst_cyc);
    logic          acc_wr [$];
    logic [AW-1:0] acc_ad [$];
    logic [S-1:0]  held;
    logic [S-1:0]  wdat;
    int            k;
    int            c;
    bit            aborted;
    held = '0;
    for (int i = 0; i < n; i++) begin
      if (!m) begin
        acc_wr.push_back(1'b0);
        acc_ad.push_back(s + AW'(i));
      end
      acc_wr.push_back(1'b1);
      acc_ad.push_back(d + AW'(i));
    end
    exp_q.push_back(pack(0, 0, 0, 0, '0, '0));
    k = 0;
    c = 1;
    aborted = 0;
    while (k < acc_wr.size()) begin
      if (c == rst_cyc) begin
        exp_q.push_back(pack(1, 0, 0, 0, '0, '0));
        aborted = 1;
        break;
      end
      if (hmask[c]) begin
        exp_q.push_back(pack(1, 0, 0, 0, '0, '0));
      end else if (!acc_wr[k]) begin
        held = exp_mem[acc_ad[k]];
        exp_q.push_back(pack(1, 0, 1, 0, acc_ad[k], '0));
        k++;
      end else begin
        wdat = m ? f : held;
        exp_q.push_back(pack(1, 0, 0, 1, acc_ad[k], wdat));
        exp_mem[acc_ad[k]] = wdat;
        k++;
      end
      c++;
    end
    if (!aborted) exp_q.push_back(pack(0, 1, 0, 0, '0, '0));
    exp_q.push_back(pack(0, 0, 0, 0, '0, '0));
  endtask

  // Drives one command and compares the bus every cycle at the falling edge.
  task automatic run_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input int n, input logic [S-1:0] f,
                        input logic [63:0] hmask, input int rst_cyc, input int extra_cyc,
                        output int done_cyc, output int done_cnt,
                        output int wr_cnt, output int rd_cnt);
    int            ncyc;
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    build_model(m, s, d, n, f, hmask, rst_cyc);
    ncyc = exp_q.size();
    done_cyc = -1;
    done_cnt = 0;
    wr_cnt = 0;
    rd_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      start    = (c == 0) || (c == extra_cyc);
      mode     = (c == extra_cyc) ? 1'b0 : m;
      src      = (c == extra_cyc) ? 8'h10 : s;
      dst      = (c == extra_cyc) ? 8'h80 : d;
      len      = (c == extra_cyc) ? 9'd3 : 9'(n);
      fill_val = f;
      hold     = hmask[c];
      rst      = (c == rst_cyc);
      @(negedge clk);
      e = exp_q.pop_front();
      act = pack(busy, done, bus.mread, bus.mwrite, bus.a, bus.din);
      check($sformatf("cycle%0d", c), 64'(act), 64'(e));
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (bus.mwrite) wr_cnt++;
      if (bus.mread)  rd_cnt++;
      @(posedge clk);
      #1;
    end
    start = 0;
    hold  = 0;
    rst   = 0;
  endtask

  task automatic check_mem_image(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < L; i++) if (mem[i] !== exp_mem[i]) nbad++;
    check(name, 64'(nbad), 64'd0);
  endtask

  initial begin
    int dc, dn, wc, rc;
    rst = 1; start = 0; mode = 0; src = '0; dst = '0; len = '0;
    fill_val = '0; hold = 0; mem_init = 1;
    for (int i = 0; i < L; i++) exp_mem[i] = init_val(i);
    @(posedge clk);
    #1;
    mem_init = 0;
    start = 1;
    len = 9'd4;
    @(negedge clk);
    check("rst_bus_quiet", 64'({busy, done, bus.mread, bus.mwrite, bus.a, bus.din}), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    start = 0;
    @(negedge clk);
    check("idle_after_rst", 64'({busy, done, bus.mread, bus.mwrite, bus.a, bus.din}), 64'd0);
    check("state_idle", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;

    // Copy 4 words 0x10 -> 0x40
    run_op(0, 8'h10, 8'h40, 4, '0, 64'd0, -1, -1, dc, dn, wc, rc);
    check("copy_done_cycle", 64'(dc), 64'd9);
    check("copy_wr_count", 64'(wc), 64'd4);
    check("copy_w0", 64'(mem[8'h40]), 64'h AAAA_00A0);
    check("copy_w3", 64'(mem[8'h43]), 64'h AAAA_00A3);
    check_mem_image("copy_image");

    // Fill with pointer wrap
    run_op(1, 8'h00, 8'hFE, 3, 32'hDEAD_BEEF, 64'd0, -1, -1, dc, dn, wc, rc);
    check("fill_done_cycle", 64'(dc), 64'd4);
    check("fill_fe", 64'(mem[8'hFE]), 64'hDEAD_BEEF);
    check("fill_ff", 64'(mem[8'hFF]), 64'hDEAD_BEEF);
    check("fill_00", 64'(mem[8'h00]), 64'hDEAD_BEEF);
    check("fill_01_kept", 64'(mem[8'h01]), 64'hC0DE_0003);
    check_mem_image("fill_image");

    // Zero length
    run_op(0, 8'h10, 8'h70, 0, '0, 64'd0, -1, -1, dc, dn, wc, rc);
    check("zero_done_cycle", 64'(dc), 64'd1);
    check("zero_strobes", 64'(wc + rc), 64'd0);
    check_mem_image("zero_image");

    // Copy with hold in cycles 2 and 3
    run_op(0, 8'h10, 8'h50, 2, '0, 64'b1100, -1, -1, dc, dn, wc, rc);
    check("hold_done_cycle", 64'(dc), 64'd7);
    check("hold_w0", 64'(mem[8'h50]), 64'hAAAA_00A0);
    check("hold_w1", 64'(mem[8'h51]), 64'hAAAA_00A1);
    check_mem_image("hold_image");

    // Reset mid-fill at cycle 4
    run_op(1, 8'h00, 8'h20, 8, 32'h1234_5678, 64'd0, 4, -1, dc, dn, wc, rc);
    check("rst_wr_count", 64'(wc), 64'd3);
    check("rst_done_count", 64'(dn), 64'd0);
    check("rst_w22", 64'(mem[8'h22]), 64'h1234_5678);
    check("rst_w23_kept", 64'(mem[8'h23]), 64'hC0DE_0069);
    check_mem_image("rst_image");

    // Second start during a copy must be ignored
    run_op(0, 8'h10, 8'h60, 3, '0, 64'd0, -1, 3, dc, dn, wc, rc);
    check("busy_start_done_count", 64'(dn), 64'd1);
    check("busy_start_done_cycle", 64'(dc), 64'd7);
    check("busy_start_80_kept", 64'(mem[8'h80]), 64'hC0DE_0180);
    check_mem_image("busy_start_image");

    // Overlapping ascending copy propagates the first word
    run_op(0, 8'h10, 8'h11, 3, '0, 64'd0, -1, -1, dc, dn, wc, rc);
    check("overlap_11", 64'(mem[8'h11]), 64'hAAAA_00A0);
    check("overlap_13", 64'(mem[8'h13]), 64'hAAAA_00A0);
    check_mem_image("overlap_image");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
